// File: rtl/div_seq.sv
// rtl/div_seq.sv - sequential restoring divider, one quotient bit per clock, start/done handshake
module div_seq #(
   parameter int DW = 32,
   parameter int VW = 16
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  logic [DW-1:0] dividend,
   input  logic [VW-1:0] divisor,
   output logic [DW-1:0] quotient,
   output logic [VW-1:0] remainder,
   output logic          done,
   output logic          busy,
   output logic          dbz
);

   localparam int CW = (DW > 1) ? $clog2(DW) : 1;

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t        state;
   logic [CW-1:0] cnt;
   logic [VW-1:0] prem;
   logic [DW-1:0] work;
   logic [VW-1:0] dvs;

   // After each restore step the partial remainder is below the divisor, so its
   // top bit is always zero; only the shifted value needs the extra bit.
   logic [VW:0]   shifted;
   logic          ge;
   logic [VW-1:0] diff;
   logic [VW-1:0] prem_next;
   logic [DW-1:0] work_next;

   always_comb begin
      shifted   = {prem, work[DW-1]};
      ge        = (shifted >= {1'b0, dvs});
      diff      = shifted[VW-1:0] - dvs;
      prem_next = ge ? diff : shifted[VW-1:0];
      work_next = {work[DW-2:0], ge};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         cnt       <= '0;
         prem      <= '0;
         work      <= '0;
         dvs       <= '0;
         quotient  <= '0;
         remainder <= '0;
         done      <= 1'b0;
         busy      <= 1'b0;
         dbz       <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  dvs  <= divisor;
                  busy <= 1'b1;
                  if (divisor == '0) begin
                     quotient  <= '1;
                     remainder <= '1;
                     dbz       <= 1'b1;
                     done      <= 1'b1;
                     state     <= DONE;
                  end else begin
                     cnt   <= '0;
                     prem  <= '0;
                     work  <= dividend;
                     state <= CALC;
                  end
               end
            end
            CALC: begin
               prem <= prem_next;
               work <= work_next;
               cnt  <= cnt + 1'b1;
               if (cnt == CW'(DW - 1)) begin
                  quotient  <= work_next;
                  remainder <= prem_next;
                  dbz       <= 1'b0;
                  done      <= 1'b1;
                  state     <= DONE;
               end
            end
            DONE: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_div_seq.sv
// tb/tb_div_seq.sv - self-checking bench for div_seq: vector table, corner sequences, random vs model
module tb_div_seq;

   localparam int DW = 32;
   localparam int VW = 16;

   logic          clk;
   logic          rst_n;
   logic          start;
   logic [DW-1:0] dividend;
   logic [VW-1:0] divisor;
   logic [DW-1:0] quotient;
   logic [VW-1:0] remainder;
   logic          done;
   logic          busy;
   logic          dbz;

   int checks = 0;
   int passed = 0;

   div_seq #(.DW(DW), .VW(VW)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .dividend(dividend), .divisor(divisor),
      .quotient(quotient), .remainder(remainder), .done(done), .busy(busy), .dbz(dbz)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic [DW-1:0] dd;
      logic [VW-1:0] dv;
      logic [DW-1:0] q;
      logic [VW-1:0] r;
      logic          dz;
   } vec_t;

   vec_t tbl[8];

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h", name, got, exp);
   endtask

   // Reference model straight from arithmetic definitions
   task automatic model(input logic [DW-1:0] dd, input logic [VW-1:0] dv,
                        output logic [DW-1:0] q, output logic [VW-1:0] r, output logic dz);
      if (dv == 0) begin
         q = '1; r = '1; dz = 1'b1;
      end else begin
         q = dd / DW'(dv); r = VW'(dd % DW'(dv)); dz = 1'b0;
      end
   endtask

   task automatic run_div(input string tag, input logic [DW-1:0] dd, input logic [VW-1:0] dv,
                          input logic [DW-1:0] eq, input logic [VW-1:0] er, input logic ed);
      int lat;
      bit busy_ok;
      @(negedge clk);
      dividend = dd; divisor = dv; start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      lat = 0; busy_ok = 1'b1;
      while (!done && lat < 100) begin
         if (!busy) busy_ok = 1'b0;
         @(negedge clk);
         lat++;
      end
      if (!busy) busy_ok = 1'b0;
      chk($sformatf("%s latency", tag), 64'(lat), (dv == 0) ? 64'd0 : 64'(DW));
      chk($sformatf("%s busy", tag), 64'(busy_ok), 64'd1);
      chk($sformatf("%s quotient", tag), 64'(quotient), 64'(eq));
      chk($sformatf("%s remainder", tag), 64'(remainder), 64'(er));
      chk($sformatf("%s dbz", tag), 64'(dbz), 64'(ed));
      @(negedge clk);
      chk($sformatf("%s after done/busy", tag), {62'd0, done, busy}, 64'd0);
   endtask

   initial begin
      logic [DW-1:0] q, dd;
      logic [VW-1:0] r, dv;
      logic          dz;
      int            ndone, t0, t1, t2, nd;
      bit            ok;

      tbl[0] = '{32'd1000,       16'd7,      32'd142,        16'd6,      1'b0};
      tbl[1] = '{32'hFFFF_FFFF,  16'hFFFF,   32'h0001_0001,  16'd0,      1'b0};
      tbl[2] = '{32'hFFFF_FFFF,  16'd1,      32'hFFFF_FFFF,  16'd0,      1'b0};
      tbl[3] = '{32'd3,          16'hFFFF,   32'd0,          16'd3,      1'b0};
      tbl[4] = '{32'd0,          16'd5,      32'd0,          16'd0,      1'b0};
      tbl[5] = '{32'd7,          16'd9,      32'd0,          16'd7,      1'b0};
      tbl[6] = '{32'd5,          16'd0,      32'hFFFF_FFFF,  16'hFFFF,   1'b1};
      tbl[7] = '{32'd10,         16'd3,      32'd3,          16'd1,      1'b0};

      rst_n = 1'b0; start = 1'b0; dividend = '0; divisor = '0;
      repeat (3) @(negedge clk);
      chk("reset outputs", {quotient, remainder, done, busy, dbz}, 64'd0);
      rst_n = 1'b1;

      for (int i = 0; i < 8; i++)
         run_div($sformatf("vec%0d", i), tbl[i].dd, tbl[i].dv, tbl[i].q, tbl[i].r, tbl[i].dz);

      // start while busy is ignored; previous result (10/3) held until done
      @(negedge clk);
      dividend = 32'd1000; divisor = 16'd7; start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0; ndone = 0; ok = 1'b1;
      for (int i = 0; i < 46; i++) begin
         if (i == 4) begin dividend = 32'd50; divisor = 16'd5; start = 1'b1; end
         if (i == 5) start = 1'b0;
         if (done) begin
            ndone++;
            chk("busy-start quotient", 64'(quotient), 64'd142);
            chk("busy-start remainder", 64'(remainder), 64'd6);
         end else if (ndone == 0 && (quotient != 32'd3 || remainder != 16'd1)) ok = 1'b0;
         @(negedge clk);
      end
      chk("busy-start done count", 64'(ndone), 64'd1);
      chk("busy-start outputs held", 64'(ok), 64'd1);

      // start held high: one result every DW+2 cycles
      dividend = 32'd100; divisor = 16'd9; start = 1'b1;
      nd = 0; t0 = 0; t1 = 0; t2 = 0;
      for (int i = 0; i < 150 && nd < 3; i++) begin
         @(negedge clk);
         if (done) begin
            if (nd == 0) t0 = i; else if (nd == 1) t1 = i; else t2 = i;
            nd++;
            chk($sformatf("held-start q%0d", nd), 64'(quotient), 64'd11);
            chk($sformatf("held-start r%0d", nd), 64'(remainder), 64'd1);
            if (nd == 3) start = 1'b0;
         end
      end
      start = 1'b0;
      chk("held-start pulses", 64'(nd), 64'd3);
      chk("held-start period1", 64'(t1 - t0), 64'(DW + 2));
      chk("held-start period2", 64'(t2 - t1), 64'(DW + 2));
      repeat (4) @(negedge clk);

      // reset mid-operation aborts without a result
      dividend = 32'd1000; divisor = 16'd7; start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      repeat (10) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("abort reset outputs", {quotient, remainder, done, busy, dbz}, 64'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      ok = 1'b1;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (done || busy || quotient != 0 || remainder != 0 || dbz) ok = 1'b0;
      end
      chk("abort no done, outputs zero", 64'(ok), 64'd1);
      run_div("after-abort 20/6", 32'd20, 16'd6, 32'd3, 16'd2, 1'b0);

      for (int n = 0; n < 150; n++) begin
         dd = $urandom();
         case ($urandom_range(0, 3))
            0: dv = 16'($urandom_range(0, 3));
            1: dv = 16'($urandom_range(0, 255));
            default: dv = 16'($urandom());
         endcase
         if (n % 5 == 0) dd = dd >> $urandom_range(0, 31);
         model(dd, dv, q, r, dz);
         run_div($sformatf("rand%0d %0h/%0h", n, dd, dv), dd, dv, q, r, dz);
      end

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
